// File: rtl/io_out_buf.sv
// -----------------------------------------------------------------------------
// io_out_buf
//
// Output buffer between a processor's output port and a downstream consumer.
// Each processor output strobe pushes an {addr_out, io_out} pair into a
// DEPTH-entry circular FIFO. The head entry is presented first-word-fall-
// through on m_data/m_addr with a valid/ready handshake. Writes arriving
// while the FIFO is full, with no read in the same cycle, are dropped and
// recorded in a sticky overflow flag.
//
// Parameters
//   NBMANT  mantissa width of the processor data word
//   NBEXPO  exponent width; data word width W = NBMANT + NBEXPO + 1
//   NUIOOU  number of processor output addresses; address width A = clog2
//   DEPTH   FIFO entries (power of two, at least 2)
//
// Ports
//   clk       clock, all state updates on the rising edge
//   rst       synchronous active-low reset
//   io_out    processor output data word (W)
//   addr_out  processor output port address (A)
//   out_en    processor output strobe, one write per cycle high
//   ovf_clr   clears the sticky overflow flag
//   m_data    data at FIFO head (W)
//   m_addr    address at FIFO head (A)
//   m_valid   head holds a valid entry
//   m_ready   downstream accepts the head entry
//   full      FIFO holds DEPTH entries
//   count     number of stored entries
//   ovf       sticky flag: at least one write was dropped
// -----------------------------------------------------------------------------
module io_out_buf #(
  parameter int NBMANT = 16,
  parameter int NBEXPO = 6,
  parameter int NUIOOU = 8,
  parameter int DEPTH  = 8,
  localparam int W  = NBMANT + NBEXPO + 1,
  localparam int A  = $clog2(NUIOOU),
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  io_out,
  input  logic [A-1:0]  addr_out,
  input  logic          out_en,
  input  logic          ovf_clr,
  output logic [W-1:0]  m_data,
  output logic [A-1:0]  m_addr,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          ovf
);

  // Storage and control state.
  logic [W-1:0]  data_q [DEPTH];
  logic [W-1:0]  data_d [DEPTH];
  logic [A-1:0]  addr_q [DEPTH];
  logic [A-1:0]  addr_d [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  // Per-cycle decisions.
  logic not_empty;
  logic is_full;
  logic rd_en;
  logic wr_en;
  logic drop;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    data_d  = data_q;
    addr_d  = addr_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;

    not_empty = (count_q != '0);
    is_full   = (count_q == CW'(DEPTH));

    // A read frees a slot at the same edge, so a full FIFO can still accept
    // a write when the head is being taken. An empty FIFO never bypasses:
    // m_ready with no valid head is simply ignored.
    rd_en = not_empty && m_ready;
    wr_en = out_en && (!is_full || rd_en);
    drop  = out_en && !wr_en;

    if (wr_en) begin
      data_d[wp_q] = io_out;
      addr_d[wp_q] = addr_out;
      wp_d         = wp_q + PW'(1);  // power-of-two depth wraps naturally
    end

    if (rd_en) begin
      rp_d = rp_q + PW'(1);
    end

    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear must stay visible.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      // NOTE: the storage array is reset as well, because the head outputs
      // must read zero after reset; this keeps it in flops rather than RAM.
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        addr_q[i] <= '0;
      end
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
        addr_q[i] <= addr_d[i];
      end
    end
  end

  // Outputs depend only on state: storage/rp for the head, count for flags.
  assign m_data  = data_q[rp_q];
  assign m_addr  = addr_q[rp_q];
  assign m_valid = (count_q != '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign ovf     = ovf_q;

endmodule

// File: doc/io_out_buf.md
IO_OUT_BUF -- requirements
Module: io_out_buf

Interface
- REQ-001 Parameter NBMANT, default 16: mantissa width of the processor data word.
- REQ-002 Parameter NBEXPO, default 6: exponent width; data word width W = NBMANT+NBEXPO+1 (23 by default).
- REQ-003 Parameter NUIOOU, default 8: number of processor output addresses; address width A = $clog2(NUIOOU).
- REQ-004 Parameter DEPTH, default 8: FIFO entries; SHALL be a power of two, at least 2.
- REQ-005 clk  input  1: single clock; all state updates on its rising edge.
- REQ-006 rst  input  1: reset, synchronous, active-low.
- REQ-007 io_out  input  W: processor output data word.
- REQ-008 addr_out  input  A: processor output port address.
- REQ-009 out_en  input  1: processor output strobe; one write per cycle it is high.
- REQ-010 ovf_clr  input  1: clears the sticky overflow flag.
- REQ-011 m_data  output  W: data at the FIFO head.
- REQ-012 m_addr  output  A: address at the FIFO head.
- REQ-013 m_valid  output  1: FIFO head holds a valid entry.
- REQ-014 m_ready  input  1: downstream accepts the head entry.
- REQ-015 full  output  1: count equals DEPTH.
- REQ-016 count  output  $clog2(DEPTH)+1: number of stored entries.
- REQ-017 ovf  output  1: sticky flag; at least one write was dropped.

Function
- REQ-018 The block SHALL buffer {addr_out, io_out} pairs in a DEPTH-entry circular FIFO with write pointer wp, read pointer rp and counter count; wp and rp wrap from DEPTH-1 to 0.
- REQ-019 Write: out_en=1 and (count<DEPTH, or a read occurs in the same cycle) -> store the pair at wp; wp+1.
- REQ-020 Read: m_valid=1 and m_ready=1 -> rp+1; the transfer completes at that edge.
- REQ-021 count SHALL add 1 for a write only, subtract 1 for a read only, and stay unchanged for a simultaneous write and read.
- REQ-022 m_valid = (count != 0); m_data and m_addr SHALL show the entry at rp. The head is first-word-fall-through: write at edge N -> m_valid=1 and data visible after edge N.
- REQ-023 Empty FIFO, out_en=1 and m_ready=1 in the same cycle: write only. There is no bypass; the word appears after the edge.
- REQ-024 Full FIFO, out_en=1 and a read in the same cycle: both occur; count stays DEPTH.
- REQ-025 Full FIFO, out_en=1 and no read: the write is dropped; wp and count are unchanged; ovf=1 from the next cycle.
- REQ-026 ovf SHALL stay set until ovf_clr=1. If ovf_clr and a drop occur in the same cycle, the set wins.
- REQ-027 m_ready while m_valid=0 has no effect.
- REQ-028 full = (count == DEPTH).
- REQ-029 Combinational paths SHALL be only storage/rp -> m_data/m_addr and count -> m_valid/full; no input-to-output combinational path.

Reset
- REQ-030 rst=0 at a rising edge SHALL set wp=0, rp=0, count=0, ovf=0 and all storage to 0. Outputs then read m_valid=0, full=0, count=0, ovf=0, m_data=0, m_addr=0.
- REQ-031 Reset SHALL override any same-cycle out_en, m_ready or ovf_clr. Entries in flight at reset are discarded.

Verification
- REQ-032 Single word: reset, then out_en=1, io_out=0x12345, addr_out=3 for one cycle, m_ready=0 -> next cycle m_valid=1, m_data=0x12345, m_addr=3, count=1. Then m_ready=1 for one cycle -> m_valid=0, count=0.
- REQ-033 Fill and order: 8 writes with data 1..8, addresses 0..7, m_ready=0 -> full=1, count=8. Drain with m_ready=1 -> data 1..8 in order, one per cycle, with pointer wrap exercised.
- REQ-034 Overflow: full FIFO plus one write of 0x99 with m_ready=0 -> count=8, ovf=1, 0x99 never appears. ovf_clr=1 -> ovf=0. Simultaneous drop and ovf_clr -> ovf=1.
- REQ-035 Full with simultaneous write and read: full FIFO, out_en=1 (data 0xAA) and m_ready=1 -> count stays 8, head advances, 0xAA emerges eighth.
- REQ-036 Reset mid-operation: 5 entries stored, ovf=1, rst=0 for one cycle with out_en=1 -> count=0, m_valid=0, ovf=0, m_data=0. The next write is the first word out.
- REQ-037 Random stress: 10k cycles of random out_en, m_ready and ovf_clr against a scoreboard model -> no data loss except counted drops, no reordering, and count always in 0..8.
